// File: rtl/uart_rx_led_top.sv
// UART 8N1 receiver driving four LEDs.
// Shows the last received byte or the byte count, selected by switches.
module uart_rx_led_top #(
  parameter int BIT_RATE = 115200,
  parameter int CLK_HZ   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_0,
  input  logic       uart_rxd,
  output logic [3:0] led
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rx_m;
  logic        rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        half_tick;
  logic        bit_tick;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  last_byte;
  logic [3:0]  byte_count;
  logic        unused_sw;

  assign unused_sw = sw_0[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rxd;
      rx_s <= rx_m;
    end
  end

  assign half_tick = (cnt == CW'(HALF_BIT - 1));
  assign bit_tick  = (cnt == CW'(CYCLES_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (!rx_s) state_nx = START;
      START:     if (half_tick) state_nx = rx_s ? IDLE : DATA;
      DATA:      if (bit_tick && bit_idx == 3'd7) state_nx = STOP;
      STOP:      if (bit_tick) state_nx = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_valid = (state == STOP) && bit_tick && rx_s;
    rx_data  = shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        START: cnt <= half_tick ? '0 : cnt + 1'b1;
        DATA: begin
          if (bit_tick) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP:    cnt <= bit_tick ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte  <= '0;
      byte_count <= '0;
    end else if (rx_valid) begin
      byte_count <= byte_count + 1'b1;
      if (!sw_0[2]) last_byte <= rx_data;
    end
  end

  // Count display takes priority over nibble select.
  always_ff @(posedge clk) begin
    if (rst)          led <= '0;
    else if (sw_0[3]) led <= byte_count;
    else if (sw_0[1]) led <= last_byte[3:0];
    else              led <= last_byte[7:4];
  end

endmodule

// File: tb/tb_uart_rx_led_top.sv
// Bench for uart_rx_led_top: directed frames plus random bytes
// checked against a byte-level model of the display.
module tb_uart_rx_led_top;

  localparam int BIT_RATE = 11520;
  localparam int CLK_HZ   = 1152000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_0;
  logic       uart_rxd;
  logic [3:0] led;

  int n_cmp = 0;
  int n_err = 0;
  int m_last;
  int m_cnt;

  uart_rx_led_top #(
    .BIT_RATE(BIT_RATE),
    .CLK_HZ  (CLK_HZ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_0    (sw_0),
    .uart_rxd(uart_rxd),
    .led     (led)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_led(input logic [3:0] sw);
    if (sw[3]) return 4'(m_cnt % 16);
    if (sw[1]) return 4'(m_last % 16);
    return 4'(m_last / 16);
  endfunction

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst    = 1'b0;
    m_last = 0;
    m_cnt  = 0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int stop_low);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (stop_low > 0) begin
      hold(1'b0, stop_low * CPB);
      hold(1'b1, 2 * CPB);
    end else begin
      hold(1'b1, CPB);
      m_cnt = (m_cnt + 1) % 16;
      if (!sw_0[2]) m_last = int'(b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic set_sw(input logic [3:0] s);
    sw_0 = s;
    repeat (2) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] exp);
    n_cmp++;
    assert (led === exp)
    else begin
      n_err++;
      $error("FAIL %s led=%b expected=%b", tag, led, exp);
    end
  endtask

  initial begin
    logic [7:0] seq [15];
    logic [7:0] b;
    logic       frz;

    seq = '{8'h41, 8'h31, 8'h42, 8'h32, 8'h43, 8'h33, 8'h44,
            8'h34, 8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h00,
            8'h00};

    sw_0 = 4'b0010;
    do_reset();
    check("reset_led", 4'b0000);
    set_sw(4'b1000);
    check("reset_count", 4'b0000);

    set_sw(4'b0010);
    send(8'h41, 0);
    check("A_low", exp_led(sw_0));
    set_sw(4'b0000);
    check("A_high", exp_led(sw_0));

    do_reset();
    set_sw(4'b0010);
    foreach (seq[i]) begin
      send(seq[i], 0);
      check($sformatf("seq%0d", i), exp_led(sw_0));
    end
    set_sw(4'b1010);
    check("seq_count", exp_led(sw_0));

    do_reset();
    set_sw(4'b0010);
    send(8'h41, 0);
    set_sw(4'b0110);
    send(8'h62, 0);
    check("freeze_led", exp_led(sw_0));
    set_sw(4'b1110);
    check("freeze_count", exp_led(sw_0));

    set_sw(4'b1000);
    hold(1'b0, HALF / 4);
    hold(1'b1, 2 * CPB);
    check("glitch_count", exp_led(sw_0));

    set_sw(4'b0010);
    send(8'h55, 3);
    check("frame_err_led", exp_led(sw_0));
    send(8'h33, 0);
    check("after_frame_err", exp_led(sw_0));
    set_sw(4'b1000);
    check("frame_err_count", exp_led(sw_0));

    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom);
      frz = 1'($urandom_range(0, 1));
      set_sw({1'b0, frz, 2'b10});
      send(b, 0);
      check($sformatf("rnd%0d_lo", k), exp_led(sw_0));
      set_sw({1'b0, frz, 2'b00});
      check($sformatf("rnd%0d_hi", k), exp_led(sw_0));
      set_sw({1'b1, frz, 2'b00});
      check($sformatf("rnd%0d_cnt", k), exp_led(sw_0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
